// File: rtl/start_arbiter.sv
// Round-robin sharing of one start/done core among N_REQ level-type requesters.
// Optional WAIT-state timeout enabled by defining START_ARB_TIMEOUT_EN.
module start_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TIMEOUT_W      = 16,
    localparam int ID_W          = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req_level,
    input  logic             core_done,
    output logic             core_start,
    output logic [ID_W-1:0]  grant_id,
    output logic             busy,
    output logic [N_REQ-1:0] pending,
    output logic [N_REQ-1:0] req_done,
    output logic             timeout_err
);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic [N_REQ-1:0]  prev_level;
    logic [ID_W-1:0]   last_grant;
    logic [N_REQ-1:0]  rise;
    logic [N_REQ-1:0]  clr;
    logic              sel_found;
    logic [ID_W-1:0]   sel_id;
    int                idx;
    logic              tmo_hit;

    logic              core_start_nxt, busy_nxt, timeout_err_nxt;
    logic [ID_W-1:0]   grant_id_nxt, last_grant_nxt;
    logic [N_REQ-1:0]  pending_nxt, req_done_nxt;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TIMEOUT_W)) begin : g_bad_cfg
        $error("start_arbiter: TIMEOUT_CYCLES must be in 1..2**TIMEOUT_W-1");
    end

`ifdef START_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt;

    // Counts completed WAIT cycles; hit fires on the cycle that would reach the limit.
    assign tmo_hit = (({1'b0, tmo_cnt} + 1'b1) == (TIMEOUT_W+1)'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (state == START)
            tmo_cnt <= '0;
        else if (state == WAIT)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign rise = req_level & ~prev_level;

    // Scan from the slot after the last served requester, wrapping modulo N_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        idx       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (!sel_found && pending[idx]) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_found) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (core_done || tmo_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        core_start_nxt  = 1'b0;
        grant_id_nxt    = grant_id;
        busy_nxt        = busy;
        req_done_nxt    = req_done;
        timeout_err_nxt = timeout_err;
        last_grant_nxt  = last_grant;
        clr             = '0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    grant_id_nxt   = sel_id;
                    clr[sel_id]    = 1'b1;
                    busy_nxt       = 1'b1;
                    core_start_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (core_done || tmo_hit) begin
                    req_done_nxt           = '0;
                    req_done_nxt[grant_id] = 1'b1;
                    timeout_err_nxt        = !core_done;
                end
            end
            DONE: begin
                req_done_nxt    = '0;
                timeout_err_nxt = 1'b0;
                last_grant_nxt  = grant_id;
                busy_nxt        = 1'b0;
            end
            default: ;
        endcase
        // A new edge wins over the grant clearing the same bit.
        pending_nxt = (pending & ~clr) | rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_level  <= '0;
            pending     <= '0;
            last_grant  <= ID_W'(N_REQ - 1);
            grant_id    <= '0;
            busy        <= 1'b0;
            core_start  <= 1'b0;
            req_done    <= '0;
            timeout_err <= 1'b0;
        end else begin
            prev_level  <= req_level;
            pending     <= pending_nxt;
            last_grant  <= last_grant_nxt;
            grant_id    <= grant_id_nxt;
            busy        <= busy_nxt;
            core_start  <= core_start_nxt;
            req_done    <= req_done_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

endmodule
